// File: rtl/rf_bank.sv
`default_nettype none
// ============================================================================
// Module   : rf_bank
// Purpose  : Parametrised register bank with registered write-first reads and
//            a per-register busy scoreboard. Define RF_X0_ZERO_EN to hardwire
//            register 0 to zero.
// Revision : 1.0 - initial release
// ============================================================================
module rf_bank #(
    parameter  int XLEN  = 64,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS),
    parameter  int NRD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                any_busy
);

`ifdef RF_X0_ZERO_EN
    localparam bit c_X0_ZERO = 1'b1;
`else
    localparam bit c_X0_ZERO = 1'b0;
`endif

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_wr_ok;
    logic             w_rsv_ok;

    // With x0 hardwired, accesses to address 0 are simply dropped.
    assign w_wr_ok  = wr_en  && !(c_X0_ZERO && (wr_addr  == '0));
    assign w_rsv_ok = rsv_en && !(c_X0_ZERO && (rsv_addr == '0));

    // Reservation is applied after the write clear so a new reservation wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok)
            w_busy_nxt[wr_addr] = 1'b0;
        if (w_rsv_ok)
            w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++)
                r_regs[k] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_ok)
                r_regs[wr_addr] <= wr_data;
            r_busy <= w_busy_nxt;
        end
    end

    assign any_busy = |r_busy;

    logic [XLEN-1:0] r_rd_data [NRD];
    logic            r_rd_busy [NRD];

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_byp;

            assign w_addr = rd_addr[i*AW +: AW];
            assign w_byp  = w_wr_ok && (wr_addr == w_addr);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data[i] <= '0;
                    r_rd_busy[i] <= 1'b0;
                end else if (rd_en[i]) begin
                    r_rd_data[i] <= w_byp ? wr_data : r_regs[w_addr];
                    r_rd_busy[i] <= w_busy_nxt[w_addr];
                end
            end

            assign rd_data[i*XLEN +: XLEN] = r_rd_data[i];
            assign rd_busy[i]              = r_rd_busy[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rf_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_bank
// Purpose  : Self-checking bench for rf_bank against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_bank;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

`ifdef RF_X0_ZERO_EN
    localparam bit c_X0 = 1'b1;
`else
    localparam bit c_X0 = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                any_busy;

    rf_bank #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [XLEN-1:0] m_reg     [NREGS];
    logic            m_busy    [NREGS];
    logic [XLEN-1:0] m_rd_data [NRD];
    logic            m_rd_busy [NRD];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
        for (int p = 0; p < NRD; p++) begin
            m_rd_data[p] = '0;
            m_rd_busy[p] = 1'b0;
        end
    endtask

    // Register file semantics at an edge: write lands, then reservation, then
    // enabled reads observe the updated state (write-first).
    task automatic model_edge();
        int a;
        if (wr_en && !(c_X0 && wr_addr == 0)) begin
            m_reg[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (rsv_en && !(c_X0 && rsv_addr == 0))
            m_busy[rsv_addr] = 1'b1;
        for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
                a = int'(rd_addr[p*AW +: AW]);
                m_rd_data[p] = m_reg[a];
                m_rd_busy[p] = m_busy[a];
            end
        end
    endtask

    function automatic logic model_any();
        logic r = 1'b0;
        for (int k = 0; k < NREGS; k++) r |= m_busy[k];
        return r;
    endfunction

    task automatic compare_all(input string tag);
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("%s rd_data[%0d]", tag, p), rd_data[p*XLEN +: XLEN], m_rd_data[p]);
            check($sformatf("%s rd_busy[%0d]", tag, p), rd_busy[p], m_rd_busy[p]);
        end
        check($sformatf("%s any_busy", tag), any_busy, model_any());
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        rsv_en = 0; rsv_addr = '0;
    endtask

    task automatic rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int a, input logic [XLEN-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    endtask

    task automatic rsv(input int a);
        rsv_en = 1'b1; rsv_addr = AW'(a);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        compare_all(tag);
        idle();
    endtask

    initial begin
        idle();
        model_reset();

        // Reset with a pending write that must be discarded
        rst = 1'b1;
        wr(3, 64'd7);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        rd(0, 3);
        step("reset");
        check("reset rd0 const", rd_data[0 +: XLEN], 64'd0);

        // Write then read on port 1, then hold with rd_en=0
        wr(8, 64'h2A);
        step("wr8");
        rd(1, 8);
        step("rd8");
        check("rd8 const", rd_data[XLEN +: XLEN], 64'h2A);
        rd_addr[AW +: AW] = AW'(3);
        step("hold");
        check("hold const", rd_data[XLEN +: XLEN], 64'h2A);

        // Bypass on both ports
        wr(5, 64'd1);
        step("x5=1");
        wr(5, '1); rd(0, 5); rd(1, 5);
        step("bypass");
        check("bypass p0 const", rd_data[0 +: XLEN], {XLEN{1'b1}});
        check("bypass p1 const", rd_data[XLEN +: XLEN], {XLEN{1'b1}});

        // Scoreboard
        rsv(9);
        step("rsv9");
        check("rsv9 any const", any_busy, 1'b1);
        rd(0, 9);
        step("rd9 busy");
        check("rd9 busy const", rd_busy[0], 1'b1);
        step("wait");
        wr(9, 64'd62); rd(0, 9);
        step("wr9");
        check("wr9 data const", rd_data[0 +: XLEN], 64'd62);
        check("wr9 busy const", rd_busy[0], 1'b0);
        check("wr9 any const", any_busy, 1'b0);

        // Reserve/write collision
        wr(10, 64'd11); rsv(10); rd(1, 10);
        step("collide");
        check("collide data const", rd_data[XLEN +: XLEN], 64'd11);
        check("collide busy const", rd_busy[1], 1'b1);
        check("collide any const", any_busy, 1'b1);
        wr(10, 64'd12);
        step("clr10");

        // x0 handling
        wr(0, 64'd45); rsv(0); rd(0, 0);
        step("x0 same");
        rd(0, 0);
        step("x0 next");
        check("x0 data const", rd_data[0 +: XLEN], c_X0 ? 64'd0 : 64'd45);
        check("x0 busy const", rd_busy[0], c_X0 ? 1'b0 : 1'b1);
        check("x0 any const", any_busy, c_X0 ? 1'b0 : 1'b1);

        // Randomised traffic, biased towards a few addresses to force collisions
        for (int it = 0; it < 3000; it++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 0);
            for (int p = 0; p < NRD; p++) begin
                rd_en[p] = ($urandom_range(0, 3) != 0);
                rd_addr[p*AW +: AW] = AW'(narrow ? $urandom_range(0, 3) : $urandom_range(0, NREGS-1));
            end
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'(narrow ? $urandom_range(0, 3) : $urandom_range(0, NREGS-1));
            wr_data  = {$urandom, $urandom};
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = AW'(narrow ? $urandom_range(0, 3) : $urandom_range(0, NREGS-1));
            if (it == 1500) begin
                // Asynchronous reset in the middle of traffic
                @(negedge clk);
                rst = 1'b1;
                #1;
                model_reset();
                compare_all("async rst");
                @(posedge clk);
                #1;
                compare_all("rst held");
                rst = 1'b0;
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_bank.md
Name: rf_bank

Overview:
- Parametrised successor of the datapath's fixed 64x32 two-read register bank.
- Width, depth and read-port count are configurable.
- Adds registered reads with write-first bypass, a per-register busy scoreboard for multicycle producers (loads) and an optional hardwired-zero x0.
- Sits between IR decode (register addresses), the ALU operand muxes (read data) and the writeback mux (write data).

Parameters:
XLEN, 64, data width in bits
NREGS, 32, number of registers (power of two, >= 2)
AW, $clog2(NREGS), register address width (derived, not overridden)
NRD, 2, number of read ports (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
rd_en  input  NRD  per-port read enable
rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  output  NRD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
rd_busy  output  NRD  registered busy flag of the register read on port i
wr_en  input  1  write enable
wr_addr  input  AW  write address
wr_data  input  XLEN  write data
rsv_en  input  1  reserve (mark busy) register rsv_addr
rsv_addr  input  AW  register to reserve
any_busy  output  1  OR of all busy bits, combinational from state

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- On rst high: all NREGS registers = 0, all busy bits = 0, rd_data = 0, rd_busy = 0, any_busy = 0. Reset mid-operation discards pending writes and reservations in that cycle.
- Write: wr_en=1 at a rising edge stores wr_data into reg[wr_addr] and clears busy[wr_addr].
- Reserve: rsv_en=1 sets busy[rsv_addr].
- Same-edge reserve and write to the same address: data is written, busy ends SET (the new reservation wins).
- Read latency: 1 cycle. If rd_en[i]=1 at edge N, rd_data[i] and rd_busy[i] are valid after edge N. If rd_en[i]=0, both hold their previous values.
- Write-first bypass: if wr_en=1 and wr_addr==rd_addr[i] at the same edge, rd_data[i] takes wr_data, not the old contents.
- rd_busy[i] reflects the busy bit after that edge's clear/set, with the same precedence as above.
- Multiple read ports may use the same address; each returns identical data.
- A write to a register that is not busy is legal; data is stored and busy stays 0.
- Reserving an already-busy register is legal; it stays busy. No counting: one write clears it.
- Addresses are AW bits wide, so out-of-range access is impossible.
- No combinational path from any input to rd_data or rd_busy.

Optional Feature:
- Macro: RF_X0_ZERO_EN.
- Defined: register 0 reads as 0 on every port.
  - Writes to address 0 are ignored, including the bypass: a read of 0 returns 0 even when wr_addr=0.
  - rsv_en to address 0 is ignored; busy[0] stays 0 permanently.
- Undefined: register 0 is an ordinary register with identical behaviour to the others. This matches the legacy bank, which initialises x0 to nonzero values.

Test Plan:
1. Reset: hold rst=1 with wr_en=1, wr_addr=3, wr_data=7; release rst, then read addr 3 on port 0 -> rd_data[0]=0, rd_busy[0]=0, any_busy=0.
2. Write then read: write 0x2A to x8 at edge 1; read x8 on port 1 at edge 2 -> rd_data[1]=0x2A after edge 2. Read x8 with rd_en=0 -> output holds its previous value.
3. Bypass: x5 holds 1; same edge write x5=0xFFFF_FFFF_FFFF_FFFF and read x5 on ports 0 and 1 -> both ports return all-ones after that edge.
4. Scoreboard: rsv x9 at edge 1 -> any_busy=1 and a read of x9 shows rd_busy=1. Write x9=62 at edge 4 with a same-edge read -> rd_data=62, rd_busy=0, any_busy=0.
5. Reserve/write collision: same edge rsv_en and wr_en to x10 (data 11) -> reg[10]=11, busy[10]=1, any_busy=1.
6. x0 with RF_X0_ZERO_EN:
   - Defined: write x0=45, rsv x0, read x0 same edge and next edge -> rd_data=0, rd_busy=0, any_busy=0.
   - Undefined: same stimulus -> rd_data=45 via bypass, busy[0]=1.
